// File: rtl/sr_cmd_debounce.sv
// Synchronises and debounces raw set/clear requests and turns their rising edges
// into fixed-length, never-00 command pulses for the SR latch, tracking its state.
module sr_cmd_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int PULSE_LEN = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic rst_req,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict,
    output logic drop,
    output logic q_model
);

    localparam int DB_W = $clog2(DB_CYCLES) + 1;
    localparam int PL_W = $clog2(PULSE_LEN) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [PL_W-1:0] PL_LAST = PL_W'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SET_PULSE = 2'd1,
        CLR_PULSE = 2'd2
    } state_t;

    // Channel index 0 is the set request, index 1 the clear request.
    logic [1:0]      sync1_r;
    logic [1:0]      sync2_r;
    logic [1:0]      lvl_r;
    logic [1:0]      lvl_d_r;
    logic [1:0]      lvl_nxt_s;
    logic [DB_W-1:0] db_cnt_r   [2];
    logic [DB_W-1:0] db_cnt_nxt_s [2];
    logic [1:0]      evt_s;
    logic            set_evt_s;
    logic            rst_evt_s;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [PL_W-1:0] pcnt_r;
    logic [PL_W-1:0] pcnt_nxt_s;
    logic            s_r;
    logic            s_nxt_s;
    logic            r_r;
    logic            r_nxt_s;
    logic            q_r;
    logic            q_nxt_s;
    logic            busy_r;
    logic            conflict_r;
    logic            conflict_nxt_s;
    logic            drop_r;
    logic            drop_nxt_s;

    // Two-flop synchronisers for both raw request lines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= {rst_req, set_req};
            sync2_r <= sync1_r;
        end
    end

    // Debounce next-state: a level only flips after DB_CYCLES consecutive mismatches.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lvl_nxt_s[i]    = lvl_r[i];
            db_cnt_nxt_s[i] = {DB_W{1'b0}};
            if (sync2_r[i] != lvl_r[i]) begin
                if (db_cnt_r[i] == DB_LAST) begin
                    lvl_nxt_s[i]    = ~lvl_r[i];
                    db_cnt_nxt_s[i] = {DB_W{1'b0}};
                end else begin
                    db_cnt_nxt_s[i] = db_cnt_r[i] + DB_W'(1'b1);
                end
            end else begin
                db_cnt_nxt_s[i] = {DB_W{1'b0}};
            end
        end
    end

    // Debounced levels, their one-cycle-delayed copies and mismatch counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_r   <= 2'b00;
            lvl_d_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                db_cnt_r[i] <= {DB_W{1'b0}};
            end
        end else begin
            lvl_r   <= lvl_nxt_s;
            lvl_d_r <= lvl_r;
            for (int i = 0; i < 2; i++) begin
                db_cnt_r[i] <= db_cnt_nxt_s[i];
            end
        end
    end

    assign evt_s     = lvl_r & ~lvl_d_r;
    assign set_evt_s = evt_s[0];
    assign rst_evt_s = evt_s[1];

    // Command FSM next-state: accepts one event in IDLE, discards events while pulsing.
    always_comb begin
        state_nxt_s    = state_r;
        pcnt_nxt_s     = pcnt_r;
        s_nxt_s        = s_r;
        r_nxt_s        = r_r;
        q_nxt_s        = q_r;
        conflict_nxt_s = 1'b0;
        drop_nxt_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (set_evt_s && rst_evt_s) begin
                    conflict_nxt_s = 1'b1;
                end else if (set_evt_s) begin
                    state_nxt_s = SET_PULSE;
                    pcnt_nxt_s  = {PL_W{1'b0}};
                    s_nxt_s     = 1'b0;
                    r_nxt_s     = 1'b1;
                    q_nxt_s     = 1'b1;
                end else if (rst_evt_s) begin
                    state_nxt_s = CLR_PULSE;
                    pcnt_nxt_s  = {PL_W{1'b0}};
                    s_nxt_s     = 1'b1;
                    r_nxt_s     = 1'b0;
                    q_nxt_s     = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SET_PULSE, CLR_PULSE: begin
                drop_nxt_s = set_evt_s | rst_evt_s;
                if (pcnt_r == PL_LAST) begin
                    state_nxt_s = IDLE;
                    pcnt_nxt_s  = {PL_W{1'b0}};
                    s_nxt_s     = 1'b1;
                    r_nxt_s     = 1'b1;
                end else begin
                    pcnt_nxt_s = pcnt_r + PL_W'(1'b1);
                end
            end
            default: begin
                // Unreachable encoding: fall back to a safe hold command.
                state_nxt_s = IDLE;
                pcnt_nxt_s  = {PL_W{1'b0}};
                s_nxt_s     = 1'b1;
                r_nxt_s     = 1'b1;
            end
        endcase
    end

    // Command FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pcnt_r     <= {PL_W{1'b0}};
            s_r        <= 1'b1;
            r_r        <= 1'b1;
            q_r        <= 1'b0;
            busy_r     <= 1'b0;
            conflict_r <= 1'b0;
            drop_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pcnt_r     <= pcnt_nxt_s;
            s_r        <= s_nxt_s;
            r_r        <= r_nxt_s;
            q_r        <= q_nxt_s;
            busy_r     <= (state_nxt_s != IDLE);
            conflict_r <= conflict_nxt_s;
            drop_r     <= drop_nxt_s;
        end
    end

    assign s        = s_r;
    assign r        = r_r;
    assign busy     = busy_r;
    assign conflict = conflict_r;
    assign drop     = drop_r;
    assign q_model  = q_r;

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Randomised scoreboard bench for sr_cmd_debounce: a high-level model queues the
// expected command events, an independent monitor matches what the DUT emits.
module tb_sr_cmd_debounce;

    localparam int DB = 4;
    localparam int PL = 2;

    localparam int K_END  = 0;
    localparam int K_SET  = 1;
    localparam int K_CLR  = 2;
    localparam int K_CONF = 3;
    localparam int K_DROP = 4;

    typedef struct {
        int kind;
        int cyc;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic set_req;
    logic rst_req;
    logic s;
    logic r;
    logic busy;
    logic conflict;
    logic drop;
    logic q_model;

    rec_t       exp_q[$];
    int         edge_cnt = 0;
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [1:0] exp_sr   = 2'b11;
    logic       exp_busy = 1'b0;
    logic       exp_qm   = 1'b0;

    sr_cmd_debounce #(.DB_CYCLES(DB), .PULSE_LEN(PL)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_req (set_req),
        .rst_req (rst_req),
        .s       (s),
        .r       (r),
        .busy    (busy),
        .conflict(conflict),
        .drop    (drop),
        .q_model (q_model)
    );

    always #5 clk = ~clk;

    function automatic string kname(input int k);
        case (k)
            K_END:   return "end";
            K_SET:   return "set";
            K_CLR:   return "clr";
            K_CONF:  return "conflict";
            K_DROP:  return "drop";
            default: return "none";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    endtask

    task automatic push(input int kind);
        rec_t rec;
        rec.kind = kind;
        rec.cyc  = edge_cnt;
        exp_q.push_back(rec);
    endtask

    // Reference model: sync delay, mismatch-run debounce, event scheduling by edge index.
    initial begin : model
        logic [1:0] sy1, sy2, lvl, lvl_prev, raw, evt;
        int         run [2];
        int         last_start;
        logic       kind_set, qm, active;
        sy1 = 2'b00; sy2 = 2'b00; lvl = 2'b00; lvl_prev = 2'b00;
        run[0] = 0; run[1] = 0;
        last_start = -1000; kind_set = 1'b1; qm = 1'b0;
        forever begin
            @(posedge clk);
            edge_cnt++;
            raw    = {rst_req, set_req};
            active = (edge_cnt > last_start) && (edge_cnt <= last_start + PL);
            if (!rst_n) begin
                if (active) push(K_END);
                sy1 = 2'b00; sy2 = 2'b00; lvl = 2'b00; lvl_prev = 2'b00;
                run[0] = 0; run[1] = 0;
                last_start = -1000; qm = 1'b0;
            end else begin
                evt = lvl & ~lvl_prev;
                if (active && edge_cnt == last_start + PL) push(K_END);
                if (active) begin
                    if (evt != 2'b00) push(K_DROP);
                end else if (evt == 2'b11) begin
                    push(K_CONF);
                end else if (evt[0]) begin
                    push(K_SET); last_start = edge_cnt; kind_set = 1'b1; qm = 1'b1;
                end else if (evt[1]) begin
                    push(K_CLR); last_start = edge_cnt; kind_set = 1'b0; qm = 1'b0;
                end
                lvl_prev = lvl;
                for (int i = 0; i < 2; i++) begin
                    if (sy2[i] != lvl[i]) begin
                        run[i]++;
                        if (run[i] == DB) begin
                            lvl[i] = ~lvl[i];
                            run[i] = 0;
                        end
                    end else begin
                        run[i] = 0;
                    end
                end
                sy2 = sy1;
                sy1 = raw;
            end
            exp_busy = (last_start <= edge_cnt) && (edge_cnt < last_start + PL);
            exp_sr   = exp_busy ? (kind_set ? 2'b01 : 2'b10) : 2'b11;
            exp_qm   = qm;
        end
    end

    // Monitor: per-cycle level checks plus matching observed events against the queue.
    initial begin : monitor
        logic s_prev, r_prev;
        int   obs[$];
        rec_t rec;
        s_prev = 1'b1;
        r_prev = 1'b1;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("s_r", 32'({s, r}), 32'(exp_sr));
            check("busy", 32'(busy), 32'(exp_busy));
            check("q_model", 32'(q_model), 32'(exp_qm));
            obs = {};
            if ((s && !s_prev) || (r && !r_prev)) obs.push_back(K_END);
            if (!s && s_prev) obs.push_back(K_SET);
            if (!r && r_prev) obs.push_back(K_CLR);
            if (conflict) obs.push_back(K_CONF);
            if (drop) obs.push_back(K_DROP);
            foreach (obs[k]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: got %s expected nothing (edge %0d)", kname(obs[k]), edge_cnt);
                end else begin
                    rec = exp_q.pop_front();
                    if (rec.kind != obs[k])
                        $display("FAIL event_kind: got %s expected %s (edge %0d)", kname(obs[k]), kname(rec.kind), edge_cnt);
                    check("event_edge", 32'(edge_cnt), 32'(rec.cyc));
                    n_checks++;
                    if (rec.kind == obs[k]) n_pass++;
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
                rec = exp_q.pop_front();
                n_checks++;
                $display("FAIL missing_event: got nothing expected %s at edge %0d", kname(rec.kind), rec.cyc);
            end
            s_prev = s;
            r_prev = r;
        end
    end

    task automatic step(input logic sv, input logic rv, input logic nv, input int n);
        set_req = sv;
        rst_req = rv;
        rst_n   = nv;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin : stim
        set_req = 1'b0;
        rst_req = 1'b0;
        rst_n   = 1'b0;
        // Request held through reset, then released.
        step(1'b1, 1'b0, 1'b0, 3);
        step(1'b1, 1'b0, 1'b1, 20);
        // Clean clear.
        step(1'b0, 1'b0, 1'b1, 10);
        step(1'b0, 1'b1, 1'b1, 20);
        step(1'b0, 1'b0, 1'b1, 10);
        // Bounce with 3-cycle runs, then held high.
        for (int k = 0; k < 7; k++) step((k % 2) == 0, 1'b0, 1'b1, 3);
        step(1'b1, 1'b0, 1'b1, 20);
        step(1'b0, 1'b0, 1'b1, 10);
        // Simultaneous rise.
        step(1'b1, 1'b1, 1'b1, 20);
        step(1'b0, 1'b0, 1'b1, 10);
        // Clear request lands while the set pulse is still being driven.
        step(1'b1, 1'b0, 1'b1, 1);
        step(1'b1, 1'b1, 1'b1, 20);
        step(1'b0, 1'b0, 1'b1, 10);
        // Reset while s is low.
        step(1'b1, 1'b0, 1'b1, 7);
        step(1'b0, 1'b0, 1'b0, 1);
        step(1'b0, 1'b0, 1'b1, 20);
        // Random segments.
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) != 0), int'($urandom_range(1, 8)));
        end
        step(1'b0, 1'b0, 1'b1, 20);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sr_cmd_debounce.md
# sr_cmd_debounce

Front-end stage that drives the set/reset inputs of the team's SR latch. It takes raw, bouncy set/reset request lines and synchronises and debounces them. It then resolves conflicts and emits clean, fixed-length command pulses in the latch's encoding: s=0,r=1 sets q; s=1,r=0 clears q; s=1,r=1 holds. The forbidden 00 combination is never produced. It also tracks the expected latch state so downstream logic does not need to read the latch.

## Interface
Parameters:
- DB_CYCLES, 4: consecutive synchronised samples required before a debounced level changes. Range ≥ 2.
- PULSE_LEN, 2: number of clock cycles a set or clear command is held on s/r. Range ≥ 1.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- set_req  input  1  raw set request, active high, asynchronous to clk, may bounce.
- rst_req  input  1  raw clear request, active high, asynchronous to clk, may bounce.
- s  output  1  latch set drive, registered. 0 = set command.
- r  output  1  latch clear drive, registered. 0 = clear command.
- busy  output  1  high while a command pulse is being driven.
- conflict  output  1  one-cycle pulse: set and clear events occurred in the same cycle.
- drop  output  1  one-cycle pulse: an event arrived while busy and was discarded.
- q_model  output  1  expected latch output.

## Operation
- Each raw input passes through a 2-flop synchroniser. The debouncer follows the synchroniser output.
- Debouncer, one per input: a counter of width clog2(DB_CYCLES)+1 and a debounced level.
  - If the synchronised value equals the debounced level, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter reaches DB_CYCLES-1 and the value still differs, the debounced level flips and the counter clears.
  - Any mismatch run shorter than DB_CYCLES is ignored.
- An event is a 0→1 transition of a debounced level (set_evt, rst_evt), one cycle wide. Falling transitions generate no event.
- FSM states: IDLE, SET_PULSE, CLR_PULSE. A pulse counter counts 0..PULSE_LEN-1.
  - IDLE, set_evt only → SET_PULSE. s=0, r=1, q_model←1.
  - IDLE, rst_evt only → CLR_PULSE. s=1, r=0, q_model←0.
  - IDLE, both events → stay IDLE. Pulse conflict. s/r and q_model unchanged.
  - SET_PULSE/CLR_PULSE: hold s/r until the counter reaches PULSE_LEN-1, then return to IDLE with s=1, r=1.
  - Any event arriving in SET_PULSE or CLR_PULSE is discarded and pulses drop. If both events arrive together while busy, drop is pulsed once and conflict is not pulsed.
- busy = (state != IDLE).
- Invariant: {s,r} is never 2'b00.
- Reset (rst_n=0 at a rising edge), from any state including mid-pulse:
  - s=1, r=1, busy=0, conflict=0, drop=0, q_model=0.
  - FSM→IDLE.
  - Synchroniser flops, debounced levels and all counters cleared to 0.
- A request held high through reset produces one set or clear event DB_CYCLES+2 edges after reset releases, because the debounced level restarts at 0.

## Timing
- E0 is the first rising edge that samples a raw input high, with the input held stable afterwards.
- The debounced level rises after edge E0+DB_CYCLES+1.
- The FSM enters the pulse state and s (or r) falls after edge E0+DB_CYCLES+2. That is edge E0+6 for the defaults.
- s (or r) stays low for exactly PULSE_LEN cycles. It returns high after edge E0+DB_CYCLES+2+PULSE_LEN.
- busy is high for the same PULSE_LEN cycles.
- q_model changes on the same edge that s (or r) falls.
- conflict and drop are registered. Each is high for exactly one cycle, asserted on the edge after the event.
- Back-to-back: an event first seen in IDLE on the edge that returns the FSM to IDLE is accepted. There is no dead cycle.

## Test plan
- Reset: hold rst_n=0 for 3 edges with set_req=1 → s=1, r=1, busy=0, q_model=0. After release (DB_CYCLES=4, PULSE_LEN=2): s=0 for 2 cycles starting 6 edges after release, then q_model=1.
- Clean set then clear: set_req high at E0 → s=0 after E0+6 for 2 cycles, q_model=1. rst_req high at E1 → r=0 after E1+6 for 2 cycles, q_model=0. {s,r}≠00 on every cycle.
- Bounce: set_req toggles high/low with 3-cycle runs for 20 cycles → no command and no drop. Then held high → exactly one set pulse.
- Simultaneous: set_req and rst_req rise on the same edge → conflict=1 for one cycle, s=r=1 throughout, q_model unchanged.
- Busy drop: PULSE_LEN=6. Fire a set, then rst_req rises 2 cycles later so its event lands mid-pulse → drop=1 for one cycle, no clear pulse, q_model stays 1.
- Reset mid-pulse: assert rst_n=0 while s=0 → on that edge s=1, busy=0, q_model=0, and no further pulse is produced while set_req is low.
